pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / stall / flush controller.
//
// Tracks outstanding data-SRAM transactions, an optional multi-cycle divider
// and exceptions / ERET in the M stage. It produces the per-stage stall and
// flush controls and the PC redirect request.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   lu_hazard                  load-use hazard detected in D
//   mdu_start                  divide issued from E
//   mem_req                    M-stage load/store requests data SRAM
//   mem_addr_ok, mem_data_ok   SRAM address accepted / data returned
//   exc_M[6:0], eret_M         M-stage exception vector / ERET
//   stall_F/D/E/M              hold PC / FD / DE / EM registers
//   flush_D/E/M                clear FD / DE / EM registers
//   redirect, redirect_eret    load PC from exception vector / from EPC
//   mdu_busy                   divider occupied
//   state_dbg[2:0]             current state encoding
//
// Configuration: define DIV_STALL_EN to build the divider-occupancy state
// and its counter. Without it, mdu_start is ignored and mdu_busy is 0.
// Parameter DIV_LAT (2..64) sets the divider occupancy in cycles.

module pipe_ctrl #(
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lu_hazard,
  input  logic       mdu_start,
  input  logic       mem_req,
  input  logic       mem_addr_ok,
  input  logic       mem_data_ok,
  input  logic [6:0] exc_M,
  input  logic       eret_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       redirect,
  output logic       redirect_eret,
  output logic       mdu_busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    MADDR = 3'd1,
    MDATA = 3'd2,
    MDU   = 3'd3,
    EXC   = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   eret_q, eret_d;
  logic   exc_s;

`ifdef DIV_STALL_EN
  localparam int CW = $clog2(DIV_LAT);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_mdu_start;
  assign unused_mdu_start = mdu_start;
`endif

  assign exc_s     = (|exc_M) | eret_M;
  assign state_dbg = state_q;

  // Next-state, counter and combinational stall/flush/redirect decode.
  always_comb begin
    state_d       = state_q;
    eret_d        = eret_q;
    stall_F       = 1'b0;
    stall_D       = 1'b0;
    stall_E       = 1'b0;
    stall_M       = 1'b0;
    flush_D       = 1'b0;
    flush_E       = 1'b0;
    flush_M       = 1'b0;
    redirect      = 1'b0;
    redirect_eret = 1'b0;
    mdu_busy      = 1'b0;
`ifdef DIV_STALL_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (exc_s) begin
          // Freeze for one cycle so the faulting instruction stays in M.
          {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
          eret_d  = eret_M;
          state_d = EXC;
        end else if (mem_req) begin
          if (mem_addr_ok && mem_data_ok) begin
            state_d = RUN;
          end else if (mem_addr_ok) begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
            state_d = MDATA;
          end else begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
            state_d = MADDR;
          end
`ifdef DIV_STALL_EN
        end else if (mdu_start) begin
          // Divide stays in E; a bubble is inserted into M.
          {stall_F, stall_D, stall_E} = 3'b111;
          flush_M = 1'b1;
          cnt_d   = CW'(DIV_LAT - 1);
          state_d = MDU;
`endif
        end else if (lu_hazard) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MADDR: begin
        if (mem_addr_ok && mem_data_ok) begin
          state_d = RUN;
        end else if (mem_addr_ok) begin
          {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
          state_d = MDATA;
        end else begin
          {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
        end
      end
      MDATA: begin
        if (mem_data_ok) begin
          state_d = RUN;
        end else begin
          {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
        end
      end
`ifdef DIV_STALL_EN
      MDU: begin
        mdu_busy = 1'b1;
        if (exc_s) begin
          // Exception in M aborts the divide.
          {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
          cnt_d   = '0;
          eret_d  = eret_M;
          state_d = EXC;
        end else if (cnt_q != '0) begin
          {stall_F, stall_D, stall_E} = 3'b111;
          flush_M = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
`endif
      EXC: begin
        {flush_D, flush_E, flush_M} = 3'b111;
        redirect      = 1'b1;
        redirect_eret = eret_q;
        state_d       = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, latched-ERET and divider counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      eret_q  <= 1'b0;
`ifdef DIV_STALL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      eret_q  <= eret_d;
`ifdef DIV_STALL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change 1ns after each rising
// edge; outputs are sampled 2ns later, well away from the next edge.
// Output vector order: {sF,sD,sE,sM,fD,fE,fM,redirect,redirect_eret,busy}.

module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lu_hazard, mdu_start, mem_req, mem_addr_ok, mem_data_ok, eret_M;
  logic [6:0] exc_M;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_M;
  logic       redirect, redirect_eret, mdu_busy;
  logic [2:0] state_dbg;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [9:0] O_NONE  = 10'b0000_000_000;
  localparam logic [9:0] O_STALL = 10'b1111_000_000;
  localparam logic [9:0] O_LU    = 10'b1100_010_000;
  localparam logic [9:0] O_EXC   = 10'b0000_111_100;
  localparam logic [9:0] O_ERET  = 10'b0000_111_110;
`ifdef DIV_STALL_EN
  localparam logic [9:0] O_DIVI  = 10'b1110_001_000;
  localparam logic [9:0] O_DIVB  = 10'b1110_001_001;
  localparam logic [9:0] O_DIVL  = 10'b0000_000_001;
  localparam logic [9:0] O_DIVX  = 10'b1111_000_001;
`endif

  pipe_ctrl #(.DIV_LAT(32)) dut (
    .clk(clk), .rst_n(rst_n), .lu_hazard(lu_hazard), .mdu_start(mdu_start),
    .mem_req(mem_req), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .exc_M(exc_M), .eret_M(eret_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .redirect(redirect), .redirect_eret(redirect_eret),
    .mdu_busy(mdu_busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] exp_o, input logic [2:0] exp_s);
    logic [12:0] obs, exp;
    obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M,
           redirect, redirect_eret, mdu_busy, state_dbg};
    exp = {exp_o, exp_s};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive(input logic lu, input logic ms, input logic mr,
                       input logic ao, input logic dok, input logic [6:0] ex,
                       input logic er);
    lu_hazard = lu; mdu_start = ms; mem_req = mr; mem_addr_ok = ao;
    mem_data_ok = dok; exc_M = ex; eret_M = er;
    #2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("reset", O_NONE, 3'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("idle", O_NONE, 3'd0);

    // Memory: addr_ok low 3 cycles, data_ok 2 cycles after addr_ok.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_c0", O_STALL, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_c1", O_STALL, 3'd1);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_c2", O_STALL, 3'd1);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
    chk("mem_c3_addr", O_STALL, 3'd1);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_c4", O_STALL, 3'd2);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
    chk("mem_c5_data", O_NONE, 3'd2);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_back_run", O_NONE, 3'd0);

    // Single-cycle hit, then MADDR with addr&data together.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0);
    chk("mem_hit", O_NONE, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mem_miss", O_STALL, 3'd0);
    cyc(); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0);
    chk("maddr_both", O_NONE, 3'd1);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
    chk("stray_data_ok", O_NONE, 3'd0);

    // Load-use hazard two cycles.
    cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("lu_1", O_LU, 3'd0);
    cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("lu_2", O_LU, 3'd0);

    // ERET with mem_req: exception wins, no MADDR.
    cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
    chk("eret_run", O_STALL, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("eret_exc", O_ERET, 3'd4);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("eret_after", O_NONE, 3'd0);

    // Plain exception, redirect_eret must be 0.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h10, 1'b0);
    chk("exc_run", O_STALL, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("exc_exc", O_EXC, 3'd4);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("exc_after", O_NONE, 3'd0);

`ifdef DIV_STALL_EN
    // Full divide: issue cycle + 32 busy cycles, released on the last.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("div_issue", O_DIVI, 3'd0);
    for (int i = 0; i < 32; i++) begin
      cyc(); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
      if (i < 31) chk("div_busy", O_DIVB, 3'd3);
      else        chk("div_last", O_DIVL, 3'd3);
    end
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("div_done", O_NONE, 3'd0);

    // Divide aborted by an exception in MDU cycle 10.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("div2_issue", O_DIVI, 3'd0);
    for (int i = 1; i < 10; i++) begin
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    end
    chk("div2_c9", O_DIVB, 3'd3);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h04, 1'b0);
    chk("div2_exc", O_DIVX, 3'd3);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("div2_redirect", O_EXC, 3'd4);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("div2_after", O_NONE, 3'd0);
`else
    // Without the divider option mdu_start has no effect.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mdu_ignored", O_NONE, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("mdu_ignored_next", O_NONE, 3'd0);
`endif

    // Reset while in MDATA.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
    chk("rst_to_mdata", O_STALL, 3'd0);
    cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    chk("rst_in_mdata", O_STALL, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_async", O_NONE, 3'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
      chk("rst_no_redirect", O_NONE, 3'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
